// File: rtl/counter_arb_pkg.sv
// ----------------------------------------------------------------------------
// counter_arb_pkg
// Shared types and constants for the counter read arbiter.
//   arb_state_t      : arbiter FSM states (IDLE -> AR -> R -> RSP -> IDLE)
//   RRESP_OKAY       : AXI OKAY response encoding
//   CNT_ADDR_DEFAULT : default read address of the counter register
//   CNT_PROT_DEFAULT : default ARPROT for counter reads
// ----------------------------------------------------------------------------
package counter_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RSP  = 2'd3
    } arb_state_t;

    localparam logic [1:0]  RRESP_OKAY       = 2'b00;
    localparam logic [11:0] CNT_ADDR_DEFAULT = 12'h000;
    localparam logic [2:0]  CNT_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Searches req starting at ptr and
// wrapping past N-1 back to 0; the first set bit wins.
//   req       in  N   request vector
//   ptr       in  IW  index that has highest priority this round (< N)
//   grant     out N   one-hot winner (all zero when no request)
//   grant_idx out IW  binary index of the winner (0 when no request)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    // Walk the N candidate positions in priority order. The wrap is done by
    // an explicit subtraction rather than a bit mask so that N does not have
    // to be a power of two.
    always_comb begin
        logic          found;
        int            idx;
        logic [IW-1:0] sel;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IW'(idx);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/counter_read_arbiter.sv
// ----------------------------------------------------------------------------
// counter_read_arbiter
// Shares the AXI-lite read port of the 64-bit free-running counter among
// N_REQ local requesters, one AR/R transaction at a time, round-robin.
//   aclk, aresetn          clock and asynchronous active-low reset
//   req       in  N_REQ    level request per requester (sampled in IDLE only)
//   rsp_valid out N_REQ    one-hot single-cycle completion strobe
//   rsp_data  out 64       counter sample of the last completed read
//   rsp_err   out 1        last completed read returned RRESP != OKAY
//   m_ar*                  AXI-lite read address channel (addr/prot constant)
//   m_r*                   AXI-lite read data channel
// ----------------------------------------------------------------------------
module counter_read_arbiter
    import counter_arb_pkg::*;
#(
    parameter int          N_REQ    = 4,
    parameter logic [11:0] CNT_ADDR = CNT_ADDR_DEFAULT,
    parameter logic [2:0]  CNT_PROT = CNT_PROT_DEFAULT
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] rsp_valid,
    output logic [63:0]      rsp_data,
    output logic             rsp_err,
    output logic             m_arvalid,
    input  logic             m_arready,
    output logic [11:0]      m_araddr,
    output logic [2:0]       m_arprot,
    input  logic             m_rvalid,
    output logic             m_rready,
    input  logic [1:0]       m_rresp,
    input  logic [63:0]      m_rdata
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    grant_idx_q;
    logic [N_REQ-1:0] arb_grant;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign arb_any  = (arb_grant != '0);
    assign m_araddr = CNT_ADDR;
    assign m_arprot = CNT_PROT;

    // State register. Reset drops any transaction in flight; the slave shares
    // aresetn, so no stale R beat can show up afterwards.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Winner capture and round-robin pointer. Both move only when a request
    // is accepted in IDLE, so req changes during AR/R/RSP have no effect.
    // The pointer moves one past the winner, wrapping by explicit compare.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant_idx_q <= '0;
            ptr         <= '0;
        end else if (state == IDLE && arb_any) begin
            grant_idx_q <= arb_idx;
            ptr         <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    // Response capture on the R handshake. These registers then hold until
    // the next completed read, so a requester can pick them up at leisure.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (state == R && m_rvalid) begin
            rsp_data <= m_rdata;
            rsp_err  <= (m_rresp != RRESP_OKAY);
        end
    end

    // Next-state and handshake outputs. All outputs are decoded from the
    // state alone, so arvalid stays up until the AR handshake and rready is
    // low everywhere outside R (stray rvalid is simply not accepted).
    always_comb begin
        state_nxt = state;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        rsp_valid = '0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_nxt = AR;
                end
            end
            AR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_nxt = R;
                end
            end
            R: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                rsp_valid[grant_idx_q] = 1'b1;
                state_nxt              = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_counter_read_arbiter
// Self-checking bench for counter_read_arbiter. A 4-requester instance and a
// 3-requester instance share one behavioural AXI-lite slave whose AR and R
// wait states are programmable. Expected responses go into a scoreboard
// queue when a request is raised and are popped when rsp_valid fires.
// ----------------------------------------------------------------------------
module tb_counter_read_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  req;
    logic [2:0]  req3;

    logic [3:0]  rsp_valid;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        m_arvalid;
    logic [11:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_rready;

    logic [2:0]  rsp_valid3;
    logic [63:0] rsp_data3;
    logic        rsp_err3;
    logic        m_arvalid3;
    logic [11:0] m_araddr3;
    logic [2:0]  m_arprot3;
    logic        m_rready3;

    logic        m_arready;
    logic        m_rvalid;
    logic [1:0]  m_rresp;
    logic [63:0] m_rdata;

    // slave behaviour knobs, set by the tests
    int          ar_wait;
    int          r_wait;
    logic [63:0] slave_rdata;
    logic [1:0]  slave_rresp;
    int          ar_hs_count = 0;

    int errors = 0;
    int checks = 0;

    // scoreboard
    logic [3:0]  exp_grant_q[$];
    logic [63:0] exp_data_q[$];
    logic        exp_err_q[$];

    always #5 aclk = ~aclk;

    counter_read_arbiter #(
        .N_REQ    (4),
        .CNT_ADDR (12'h000),
        .CNT_PROT (3'b000)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req       (req),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_arprot  (m_arprot),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rresp   (m_rresp),
        .m_rdata   (m_rdata)
    );

    counter_read_arbiter #(
        .N_REQ    (3),
        .CNT_ADDR (12'h000),
        .CNT_PROT (3'b000)
    ) dut3 (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req       (req3),
        .rsp_valid (rsp_valid3),
        .rsp_data  (rsp_data3),
        .rsp_err   (rsp_err3),
        .m_arvalid (m_arvalid3),
        .m_arready (m_arready),
        .m_araddr  (m_araddr3),
        .m_arprot  (m_arprot3),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready3),
        .m_rresp   (m_rresp),
        .m_rdata   (m_rdata)
    );

    // Count AR handshakes from either instance (only one is ever active).
    always @(posedge aclk) begin
        if (aresetn && m_arready && (m_arvalid || m_arvalid3)) begin
            ar_hs_count <= ar_hs_count + 1;
        end
    end

    // Behavioural slave: arready after ar_wait cycles of arvalid, rvalid on
    // the r_wait-th cycle of rready (1 = the registered zero-wait slave).
    initial begin
        int ar_cnt;
        int r_cnt;
        ar_cnt    = 0;
        r_cnt     = 0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rresp   = 2'b00;
        m_rdata   = '0;
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                ar_cnt    = 0;
                r_cnt     = 0;
                m_arready = 1'b0;
                m_rvalid  = 1'b0;
            end else begin
                if (m_arvalid || m_arvalid3) begin
                    m_arready = (ar_cnt == ar_wait);
                    ar_cnt++;
                end else begin
                    m_arready = 1'b0;
                    ar_cnt    = 0;
                end
                if (m_rready || m_rready3) begin
                    m_rvalid = (r_cnt == r_wait);
                    m_rdata  = slave_rdata;
                    m_rresp  = slave_rresp;
                    r_cnt++;
                end else begin
                    m_rvalid = 1'b0;
                    r_cnt    = 0;
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Wait up to budget cycles for a response strobe; sampled #1 after edge.
    task automatic wait_rsp(input bit use3, input int budget,
                            output logic [3:0] got, output int cycles);
        got    = '0;
        cycles = budget;
        for (int c = 1; c <= budget; c++) begin
            @(posedge aclk);
            #1;
            got = use3 ? {1'b0, rsp_valid3} : rsp_valid;
            if (got != '0) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_arvalid got=%b exp=0", m_arvalid); end
        checks++; if (m_rready !== 1'b0) begin errors++; $display("[TB] FAIL reset_rready got=%b exp=0", m_rready); end
        checks++; if (rsp_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        checks++; if (m_araddr !== 12'h000) begin errors++; $display("[TB] FAIL reset_araddr got=%h exp=000", m_araddr); end
        checks++; if (m_arprot !== 3'b000) begin errors++; $display("[TB] FAIL reset_arprot got=%b exp=000", m_arprot); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  got;
        logic [3:0]  eg;
        logic [63:0] ed;
        logic        ee;
        int          cyc;
        ar_wait     = 0;
        r_wait      = 1;
        slave_rresp = 2'b00;
        req         = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            slave_rdata = 64'h100 + 64'(i);
            exp_grant_q.push_back(4'b0001 << (i % 4));
            exp_data_q.push_back(64'h100 + 64'(i));
            exp_err_q.push_back(1'b0);
            wait_rsp(1'b0, 30, got, cyc);
            eg = exp_grant_q.pop_front();
            ed = exp_data_q.pop_front();
            ee = exp_err_q.pop_front();
            checks++; if (got !== eg) begin errors++; $display("[TB] FAIL rr_grant[%0d] got=%b exp=%b", i, got, eg); end
            checks++; if (rsp_data !== ed) begin errors++; $display("[TB] FAIL rr_data[%0d] got=%h exp=%h", i, rsp_data, ed); end
            checks++; if (rsp_err !== ee) begin errors++; $display("[TB] FAIL rr_err[%0d] got=%b exp=%b", i, rsp_err, ee); end
            if (i == 4) req = 4'b0000;
            @(posedge aclk);
            #1;
            checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL rr_single_pulse[%0d] got=%b exp=0000", i, rsp_valid); end
        end
    endtask

    task automatic test_single();
        logic [3:0]  got;
        int          cyc;
        ar_wait     = 0;
        r_wait      = 1;
        slave_rresp = 2'b00;
        slave_rdata = 64'h1234;
        exp_grant_q.push_back(4'b0001);
        exp_data_q.push_back(64'h1234);
        exp_err_q.push_back(1'b0);
        req = 4'b0001;
        @(posedge aclk);
        #1;
        checks++; if (m_arvalid !== 1'b1) begin errors++; $display("[TB] FAIL single_arvalid_t1 got=%b exp=1", m_arvalid); end
        wait_rsp(1'b0, 30, got, cyc);
        req = 4'b0000;
        checks++; if (cyc + 1 !== 4) begin errors++; $display("[TB] FAIL single_latency got=%0d exp=4", cyc + 1); end
        checks++; if (got !== exp_grant_q.pop_front()) begin errors++; $display("[TB] FAIL single_grant got=%b exp=0001", got); end
        checks++; if (rsp_data !== exp_data_q.pop_front()) begin errors++; $display("[TB] FAIL single_data got=%h exp=1234", rsp_data); end
        checks++; if (rsp_err !== exp_err_q.pop_front()) begin errors++; $display("[TB] FAIL single_err got=%b exp=0", rsp_err); end
        @(posedge aclk);
        #1;
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL single_pulse_end got=%b exp=0000", rsp_valid); end
        checks++; if (rsp_data !== 64'h1234) begin errors++; $display("[TB] FAIL single_data_hold got=%h exp=1234", rsp_data); end
    endtask

    task automatic test_stall();
        int   arv_cycles;
        int   rsp_cycle;
        int   hs_before;
        bit   addr_bad;
        arv_cycles  = 0;
        rsp_cycle   = 0;
        addr_bad    = 1'b0;
        ar_wait     = 5;
        r_wait      = 3;
        slave_rresp = 2'b00;
        slave_rdata = 64'hDEAD_BEEF_0000_0001;
        exp_grant_q.push_back(4'b0100);
        exp_data_q.push_back(64'hDEAD_BEEF_0000_0001);
        exp_err_q.push_back(1'b0);
        hs_before = ar_hs_count;
        req = 4'b0100;
        for (int c = 1; c <= 40; c++) begin
            @(posedge aclk);
            #1;
            if (m_arvalid) begin
                arv_cycles++;
                if (m_araddr !== 12'h000 || m_arprot !== 3'b000) addr_bad = 1'b1;
            end
            if (rsp_valid != 4'b0000) begin
                rsp_cycle = c;
                break;
            end
        end
        req = 4'b0000;
        checks++; if (arv_cycles !== 6) begin errors++; $display("[TB] FAIL stall_arvalid_cycles got=%0d exp=6", arv_cycles); end
        checks++; if (addr_bad !== 1'b0) begin errors++; $display("[TB] FAIL stall_addr_stable got=%b exp=0", addr_bad); end
        checks++; if (rsp_cycle !== 11) begin errors++; $display("[TB] FAIL stall_latency got=%0d exp=11", rsp_cycle); end
        checks++; if (ar_hs_count - hs_before !== 1) begin errors++; $display("[TB] FAIL stall_ar_count got=%0d exp=1", ar_hs_count - hs_before); end
        checks++; if (rsp_valid !== exp_grant_q.pop_front()) begin errors++; $display("[TB] FAIL stall_grant got=%b exp=0100", rsp_valid); end
        checks++; if (rsp_data !== exp_data_q.pop_front()) begin errors++; $display("[TB] FAIL stall_data got=%h exp=deadbeef00000001", rsp_data); end
        checks++; if (rsp_err !== exp_err_q.pop_front()) begin errors++; $display("[TB] FAIL stall_err got=%b exp=0", rsp_err); end
    endtask

    task automatic test_error();
        logic [3:0]  got;
        logic [3:0]  eg;
        logic [63:0] ed;
        logic        ee;
        int          cyc;
        ar_wait = 0;
        r_wait  = 1;
        for (int i = 0; i < 2; i++) begin
            slave_rresp = (i == 0) ? 2'b10 : 2'b00;
            slave_rdata = (i == 0) ? 64'h0 : 64'h5;
            exp_grant_q.push_back(4'b0001);
            exp_data_q.push_back((i == 0) ? 64'h0 : 64'h5);
            exp_err_q.push_back(i == 0);
            req = 4'b0001;
            wait_rsp(1'b0, 30, got, cyc);
            req = 4'b0000;
            eg = exp_grant_q.pop_front();
            ed = exp_data_q.pop_front();
            ee = exp_err_q.pop_front();
            checks++; if (got !== eg) begin errors++; $display("[TB] FAIL err_grant[%0d] got=%b exp=%b", i, got, eg); end
            checks++; if (rsp_data !== ed) begin errors++; $display("[TB] FAIL err_data[%0d] got=%h exp=%h", i, rsp_data, ed); end
            checks++; if (rsp_err !== ee) begin errors++; $display("[TB] FAIL err_flag[%0d] got=%b exp=%b", i, rsp_err, ee); end
            @(posedge aclk);
            #1;
            checks++; if (rsp_err !== ee) begin errors++; $display("[TB] FAIL err_hold[%0d] got=%b exp=%b", i, rsp_err, ee); end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0]  got;
        logic [3:0]  eg;
        int          cyc;
        bit          seen_r;
        bit          stray;
        seen_r      = 1'b0;
        stray       = 1'b0;
        ar_wait     = 0;
        r_wait      = 10;
        slave_rresp = 2'b00;
        slave_rdata = 64'h77;
        req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            @(posedge aclk);
            #1;
            if (m_rready) begin
                seen_r = 1'b1;
                break;
            end
        end
        checks++; if (seen_r !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_reach_r got=%b exp=1", seen_r); end
        aresetn = 1'b0;
        #1;
        checks++; if (m_rready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_rready got=%b exp=0", m_rready); end
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_arvalid got=%b exp=0", m_arvalid); end
        checks++; if (rsp_data !== 64'h0) begin errors++; $display("[TB] FAIL rstmid_rsp_data got=%h exp=0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_rsp_err got=%b exp=0", rsp_err); end
        req = 4'b0000;
        r_wait = 1;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge aclk);
            #1;
            if (rsp_valid != 4'b0000) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_rsp got=%b exp=0", stray); end
        // Pointer restarts at 0: with 1 and 2 requesting, 1 must win first.
        slave_rdata = 64'h88;
        exp_grant_q.push_back(4'b0010);
        exp_grant_q.push_back(4'b0100);
        req = 4'b0110;
        wait_rsp(1'b0, 30, got, cyc);
        req = 4'b0100;
        eg  = exp_grant_q.pop_front();
        checks++; if (got !== eg) begin errors++; $display("[TB] FAIL rstmid_ptr0 got=%b exp=%b", got, eg); end
        checks++; if (rsp_data !== 64'h88) begin errors++; $display("[TB] FAIL rstmid_data got=%h exp=88", rsp_data); end
        wait_rsp(1'b0, 30, got, cyc);
        req = 4'b0000;
        eg  = exp_grant_q.pop_front();
        checks++; if (got !== eg) begin errors++; $display("[TB] FAIL rstmid_req2 got=%b exp=%b", got, eg); end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_wrap_n3();
        logic [3:0]  got;
        logic [3:0]  eg;
        logic [63:0] ed;
        int          cyc;
        ar_wait     = 0;
        r_wait      = 1;
        slave_rresp = 2'b00;
        // Move the 3-requester pointer to 2 by serving requester 1.
        exp_grant_q.push_back(4'b0010);
        exp_data_q.push_back(64'hA1);
        exp_grant_q.push_back(4'b0100);
        exp_data_q.push_back(64'hA2);
        exp_grant_q.push_back(4'b0001);
        exp_data_q.push_back(64'hA3);
        for (int i = 0; i < 3; i++) begin
            slave_rdata = 64'hA1 + 64'(i);
            if (i == 0) req3 = 3'b010;
            wait_rsp(1'b1, 30, got, cyc);
            req3 = (i == 2) ? 3'b000 : 3'b101;
            eg = exp_grant_q.pop_front();
            ed = exp_data_q.pop_front();
            checks++; if (got !== eg) begin errors++; $display("[TB] FAIL wrap_grant[%0d] got=%b exp=%b", i, got, eg); end
            checks++; if (rsp_data3 !== ed) begin errors++; $display("[TB] FAIL wrap_data[%0d] got=%h exp=%h", i, rsp_data3, ed); end
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn     = 1'b0;
        req         = 4'b0000;
        req3        = 3'b000;
        ar_wait     = 0;
        r_wait      = 1;
        slave_rdata = '0;
        slave_rresp = 2'b00;
        repeat (3) @(posedge aclk);
        #1;
        test_reset();
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        test_round_robin();
        test_single();
        test_stall();
        test_error();
        test_reset_mid();
        test_wrap_n3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
